// File: rtl/idex_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : idex_reg_if
//  Description : Bus between the ID stage, the hazard unit, the WB stage and
//                the ID/EX pipeline register.
//                master : the decode / hazard / writeback side driving it
//                slave  : the ID/EX register itself
//  Revision    : 1.0  initial release
// ============================================================================
interface idex_reg_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int ALU_OP_WIDTH     = 4,
    parameter int BUBBLE_CNT_WIDTH = 16
);
    // ID-side instruction fields
    logic                        id_valid;
    logic [DATA_WIDTH-1:0]       id_pc_plus4;
    logic [DATA_WIDTH-1:0]       id_imm_ext;
    logic [DATA_WIDTH-1:0]       id_rs_data;
    logic [DATA_WIDTH-1:0]       id_rt_data;
    logic [REG_ADDR_WIDTH-1:0]   id_rs_addr;
    logic [REG_ADDR_WIDTH-1:0]   id_rt_addr;
    logic [REG_ADDR_WIDTH-1:0]   id_rd_addr;
    logic [ALU_OP_WIDTH-1:0]     id_alu_op;
    logic [1:0]                  id_alu_src;
    logic [1:0]                  id_reg_dst;
    logic                        id_reg_write;
    logic                        id_mem_read;
    logic                        id_mem_write;
    logic                        id_mem_to_reg;

    // Hazard-unit controls
    logic                        stall;
    logic                        flush;

    // Writeback port used to refresh held operands
    logic                        wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0]   wb_reg_addr;
    logic [DATA_WIDTH-1:0]       wb_data;

    // EX-side registered copies
    logic                        ex_valid;
    logic [DATA_WIDTH-1:0]       ex_pc_plus4;
    logic [DATA_WIDTH-1:0]       ex_imm_ext;
    logic [DATA_WIDTH-1:0]       ex_rs_data;
    logic [DATA_WIDTH-1:0]       ex_rt_data;
    logic [REG_ADDR_WIDTH-1:0]   ex_rs_addr;
    logic [REG_ADDR_WIDTH-1:0]   ex_rt_addr;
    logic [REG_ADDR_WIDTH-1:0]   ex_rd_addr;
    logic [ALU_OP_WIDTH-1:0]     ex_alu_op;
    logic [1:0]                  ex_alu_src;
    logic [1:0]                  ex_reg_dst;
    logic                        ex_reg_write;
    logic                        ex_mem_read;
    logic                        ex_mem_write;
    logic                        ex_mem_to_reg;

    // Performance monitor
    logic [BUBBLE_CNT_WIDTH-1:0] bubble_cnt;

    modport master (
        output id_valid, id_pc_plus4, id_imm_ext, id_rs_data, id_rt_data,
               id_rs_addr, id_rt_addr, id_rd_addr, id_alu_op, id_alu_src,
               id_reg_dst, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, stall, flush, wb_reg_write, wb_reg_addr, wb_data,
        input  ex_valid, ex_pc_plus4, ex_imm_ext, ex_rs_data, ex_rt_data,
               ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_alu_op, ex_alu_src,
               ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc_plus4, id_imm_ext, id_rs_data, id_rt_data,
               id_rs_addr, id_rt_addr, id_rd_addr, id_alu_op, id_alu_src,
               id_reg_dst, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, stall, flush, wb_reg_write, wb_reg_addr, wb_data,
        output ex_valid, ex_pc_plus4, ex_imm_ext, ex_rs_data, ex_rt_data,
               ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_alu_op, ex_alu_src,
               ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/idex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : idex_reg
//  Description : ID/EX pipeline register. Loads the decoded instruction each
//                cycle, holds it on stall (refreshing held operands from WB
//                writes), inserts an all-zero bubble on flush, and counts
//                bubble cycles with a saturating counter.
//  Revision    : 1.0  initial release
// ============================================================================
module idex_reg #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int ALU_OP_WIDTH     = 4,
    parameter int BUBBLE_CNT_WIDTH = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    idex_reg_if.slave   bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                        ex_valid_q,      ex_valid_d;
    logic [DATA_WIDTH-1:0]       ex_pc_plus4_q,   ex_pc_plus4_d;
    logic [DATA_WIDTH-1:0]       ex_imm_ext_q,    ex_imm_ext_d;
    logic [DATA_WIDTH-1:0]       ex_rs_data_q,    ex_rs_data_d;
    logic [DATA_WIDTH-1:0]       ex_rt_data_q,    ex_rt_data_d;
    logic [REG_ADDR_WIDTH-1:0]   ex_rs_addr_q,    ex_rs_addr_d;
    logic [REG_ADDR_WIDTH-1:0]   ex_rt_addr_q,    ex_rt_addr_d;
    logic [REG_ADDR_WIDTH-1:0]   ex_rd_addr_q,    ex_rd_addr_d;
    logic [ALU_OP_WIDTH-1:0]     ex_alu_op_q,     ex_alu_op_d;
    logic [1:0]                  ex_alu_src_q,    ex_alu_src_d;
    logic [1:0]                  ex_reg_dst_q,    ex_reg_dst_d;
    logic                        ex_reg_write_q,  ex_reg_write_d;
    logic                        ex_mem_read_q,   ex_mem_read_d;
    logic                        ex_mem_write_q,  ex_mem_write_d;
    logic                        ex_mem_to_reg_q, ex_mem_to_reg_d;
    logic [BUBBLE_CNT_WIDTH-1:0] bubble_cnt_q,    bubble_cnt_d;

    // ------------------------------------------------------------------
    // Operand refresh qualifiers: only a real held instruction is patched,
    // and register 0 is hard-wired so a write to it is never forwarded.
    // ------------------------------------------------------------------
    logic w_refresh_en;
    logic w_refresh_rs;
    logic w_refresh_rt;

    assign w_refresh_en = ex_valid_q && bus.wb_reg_write
                          && (bus.wb_reg_addr != '0);
    assign w_refresh_rs = w_refresh_en && (ex_rs_addr_q == bus.wb_reg_addr);
    assign w_refresh_rt = w_refresh_en && (ex_rt_addr_q == bus.wb_reg_addr);

    // Next-state selection: flush beats stall beats a normal load
    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_pc_plus4_d   = ex_pc_plus4_q;
        ex_imm_ext_d    = ex_imm_ext_q;
        ex_rs_data_d    = ex_rs_data_q;
        ex_rt_data_d    = ex_rt_data_q;
        ex_rs_addr_d    = ex_rs_addr_q;
        ex_rt_addr_d    = ex_rt_addr_q;
        ex_rd_addr_d    = ex_rd_addr_q;
        ex_alu_op_d     = ex_alu_op_q;
        ex_alu_src_d    = ex_alu_src_q;
        ex_reg_dst_d    = ex_reg_dst_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_read_d   = ex_mem_read_q;
        ex_mem_write_d  = ex_mem_write_q;
        ex_mem_to_reg_d = ex_mem_to_reg_q;

        if (bus.flush) begin
            // Bubble is bit-identical to the reset state
            ex_valid_d      = 1'b0;
            ex_pc_plus4_d   = '0;
            ex_imm_ext_d    = '0;
            ex_rs_data_d    = '0;
            ex_rt_data_d    = '0;
            ex_rs_addr_d    = '0;
            ex_rt_addr_d    = '0;
            ex_rd_addr_d    = '0;
            ex_alu_op_d     = '0;
            ex_alu_src_d    = '0;
            ex_reg_dst_d    = '0;
            ex_reg_write_d  = 1'b0;
            ex_mem_read_d   = 1'b0;
            ex_mem_write_d  = 1'b0;
            ex_mem_to_reg_d = 1'b0;
        end else if (bus.stall) begin
            // Hold everything; only the operands can pick up a WB write
            if (w_refresh_rs) begin
                ex_rs_data_d = bus.wb_data;
            end
            if (w_refresh_rt) begin
                ex_rt_data_d = bus.wb_data;
            end
        end else begin
            // Control bits load unmasked; decode zeroes them for bubbles
            ex_valid_d      = bus.id_valid;
            ex_pc_plus4_d   = bus.id_pc_plus4;
            ex_imm_ext_d    = bus.id_imm_ext;
            ex_rs_data_d    = bus.id_rs_data;
            ex_rt_data_d    = bus.id_rt_data;
            ex_rs_addr_d    = bus.id_rs_addr;
            ex_rt_addr_d    = bus.id_rt_addr;
            ex_rd_addr_d    = bus.id_rd_addr;
            ex_alu_op_d     = bus.id_alu_op;
            ex_alu_src_d    = bus.id_alu_src;
            ex_reg_dst_d    = bus.id_reg_dst;
            ex_reg_write_d  = bus.id_reg_write;
            ex_mem_read_d   = bus.id_mem_read;
            ex_mem_write_d  = bus.id_mem_write;
            ex_mem_to_reg_d = bus.id_mem_to_reg;
        end
    end

    // Bubble counter looks at the post-edge valid, so it uses the _d value
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!ex_valid_d && !(&bubble_cnt_q)) begin
            bubble_cnt_d = bubble_cnt_q + BUBBLE_CNT_WIDTH'(1);
        end
    end

    // Pipeline register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_pc_plus4_q   <= '0;
            ex_imm_ext_q    <= '0;
            ex_rs_data_q    <= '0;
            ex_rt_data_q    <= '0;
            ex_rs_addr_q    <= '0;
            ex_rt_addr_q    <= '0;
            ex_rd_addr_q    <= '0;
            ex_alu_op_q     <= '0;
            ex_alu_src_q    <= '0;
            ex_reg_dst_q    <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            bubble_cnt_q    <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_pc_plus4_q   <= ex_pc_plus4_d;
            ex_imm_ext_q    <= ex_imm_ext_d;
            ex_rs_data_q    <= ex_rs_data_d;
            ex_rt_data_q    <= ex_rt_data_d;
            ex_rs_addr_q    <= ex_rs_addr_d;
            ex_rt_addr_q    <= ex_rt_addr_d;
            ex_rd_addr_q    <= ex_rd_addr_d;
            ex_alu_op_q     <= ex_alu_op_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_reg_dst_q    <= ex_reg_dst_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_mem_to_reg_q <= ex_mem_to_reg_d;
            bubble_cnt_q    <= bubble_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_pc_plus4   = ex_pc_plus4_q;
    assign bus.ex_imm_ext    = ex_imm_ext_q;
    assign bus.ex_rs_data    = ex_rs_data_q;
    assign bus.ex_rt_data    = ex_rt_data_q;
    assign bus.ex_rs_addr    = ex_rs_addr_q;
    assign bus.ex_rt_addr    = ex_rt_addr_q;
    assign bus.ex_rd_addr    = ex_rd_addr_q;
    assign bus.ex_alu_op     = ex_alu_op_q;
    assign bus.ex_alu_src    = ex_alu_src_q;
    assign bus.ex_reg_dst    = ex_reg_dst_q;
    assign bus.ex_reg_write  = ex_reg_write_q;
    assign bus.ex_mem_read   = ex_mem_read_q;
    assign bus.ex_mem_write  = ex_mem_write_q;
    assign bus.ex_mem_to_reg = ex_mem_to_reg_q;
    assign bus.bubble_cnt    = bubble_cnt_q;

endmodule
`default_nettype wire

// File: doc/idex_reg.md
Name: idex_reg

Overview:
- ID/EX pipeline register directly downstream of the ID-stage immediate extender and decoder.
- Captures the extended immediate, register operands, register addresses, PC+4 and EX/MEM/WB control bits, and presents them to EX one cycle later.
- Supports hazard-unit stall (hold) and flush (bubble insertion).
- While holding, refreshes stale operands from WB writes, and counts bubble cycles for performance monitoring.

Parameters:
- DATA_WIDTH, 32, width of the data path, PC and extended immediate
- REG_ADDR_WIDTH, 5, register-file address width
- ALU_OP_WIDTH, 4, ALU operation code width
- BUBBLE_CNT_WIDTH, 16, width of the saturating bubble counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc_plus4  in  DATA_WIDTH  PC+4 of the ID instruction
- id_imm_ext  in  DATA_WIDTH  extended immediate from the extension stage
- id_rs_data  in  DATA_WIDTH  rs operand from the register file
- id_rt_data  in  DATA_WIDTH  rt operand from the register file
- id_rs_addr, id_rt_addr, id_rd_addr  in  REG_ADDR_WIDTH each  register addresses
- id_alu_op  in  ALU_OP_WIDTH  ALU operation
- id_alu_src  in  2  ALU B-operand select
- id_reg_dst  in  2  destination select (rt / rd / r31)
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
- stall  in  1  hold all EX-side state this cycle
- flush  in  1  replace EX-side state with a bubble
- wb_reg_write  in  1  WB stage writes the register file
- wb_reg_addr  in  REG_ADDR_WIDTH  WB destination
- wb_data  in  DATA_WIDTH  WB write data
- ex_* (one output per id_* input above, same widths)  out  registered copies
- ex_valid  out  1  EX holds a real instruction
- bubble_cnt  out  BUBBLE_CNT_WIDTH  saturating count of cycles with ex_valid=0

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n=0, every ex_* output, ex_valid and bubble_cnt are 0 immediately, independent of clk.
- Latency: 1 cycle. Values presented on id_* at edge N appear on ex_* after edge N.
- Per-edge priority is flush > stall > load.
- flush=1:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and ex_mem_to_reg are cleared to 0.
  - All other ex_* fields are also cleared to 0, giving a deterministic bubble equal to the reset state.
  - This applies regardless of stall.
- stall=1, flush=0:
  - All ex_* fields hold their values, except for the operand refresh below.
  - Operand refresh applies only when ex_valid=1, wb_reg_write=1 and wb_reg_addr≠0:
    - if ex_rs_addr==wb_reg_addr, ex_rs_data is loaded from wb_data;
    - if ex_rt_addr==wb_reg_addr, ex_rt_data is loaded from wb_data;
    - both may update in the same cycle.
  - Register 0 is never refreshed.
- stall=0, flush=0: all ex_* outputs load their id_* inputs. ex_valid loads id_valid.
- When id_valid=0 is loaded, the control bits still load as presented. The decoder guarantees they are 0.
- ex_imm_ext passes id_imm_ext unmodified. In particular, the constant-4 encoding (value 1, shifted left by 2 in EX) is not reinterpreted here.
- bubble_cnt:
  - Increments by 1 on every edge at which the post-edge ex_valid is 0.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- No state machine beyond the valid bit. The operand refresh is the only state change during a hold.

Test Plan:
- Reset mid-operation:
  - Stimulus: load a valid instruction with imm_ext=0xFFFF8000, then assert rst_n=0 between clock edges.
  - Required: all outputs read 0 before the next edge; bubble_cnt=0.
- Plain load:
  - Stimulus: id_valid=1, id_imm_ext=0x12340000, id_rs_data=0xA5A5A5A5, id_alu_op=4, id_reg_write=1.
  - Required: the same values appear on ex_* one edge later, ex_valid=1.
- Stall hold:
  - Stimulus: a loaded instruction, then stall=1 for 3 cycles while id_* change to 0xDEADBEEF.
  - Required: ex_* unchanged throughout; the new values load on the first edge after stall drops.
- Stall with WB refresh:
  - Stimulus: held ex_rs_addr=5, ex_rt_addr=5; during the stall, wb_reg_write=1, wb_reg_addr=5, wb_data=0x0000CAFE.
  - Required: ex_rs_data and ex_rt_data both become 0x0000CAFE.
  - Repeat with wb_reg_addr=0 and ex_rs_addr=0: no change to ex_rs_data.
- Flush vs stall:
  - Stimulus: stall=1 and flush=1 on the same edge with a valid instruction held, mem_write=1.
  - Required: ex_valid=0, ex_mem_write=0, all fields 0; bubble_cnt increments by 1.
- Counter saturation:
  - Stimulus: BUBBLE_CNT_WIDTH=4, ex_valid held 0 for 20 cycles.
  - Required: bubble_cnt reaches 15 and stays at 15.
